// File: rtl/execute_multdiv.sv
// Iterative signed multiply / divide unit for the execute stage; stalls the front end while busy.
// Build option: define MULTDIV_DIV_EN to include the restoring divider; otherwise div ops report an exception.
module execute_multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [31:0] instruction,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        exception,
    output logic        stall
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_op;
    logic        w_skip_busy;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_unused;

    logic [5:0]  r_count;
    logic        r_is_div;
    logic        r_neg;
    logic        r_err;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_shreg;

    logic [63:0] w_prod;
    logic        w_mul_exc;

    assign w_is_mul = (instruction[31:27] == 5'b00000) && (instruction[6:2] == 5'b00110);
    assign w_is_div = (instruction[31:27] == 5'b00000) && (instruction[6:2] == 5'b00111);
    assign w_op     = w_is_mul | w_is_div;
    assign w_unused = ^{instruction[26:7], instruction[1:0]};

    // Both algorithms work on magnitudes; the sign is re-applied when the result is presented.
    assign w_abs_a = dataA[31] ? (~dataA + 32'd1) : dataA;
    assign w_abs_b = dataB[31] ? (~dataB + 32'd1) : dataB;

`ifdef MULTDIV_DIV_EN
    logic [32:0] r_rem;
    logic [32:0] w_rem_shift;
    logic [32:0] w_rem_sub;
    logic [31:0] w_quot;
    logic        w_div_exc;

    assign w_skip_busy = w_is_div && (dataB == 32'd0);
    assign w_rem_shift = {r_rem[31:0], r_shreg[31]};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_mcand[31:0]};
    assign w_quot      = r_neg ? (~r_shreg + 32'd1) : r_shreg;
    // Only a positive quotient of 2^31 (0x80000000 / -1) cannot be represented.
    assign w_div_exc   = !r_neg && r_shreg[31];
`else
    assign w_skip_busy = w_is_div;
`endif

    assign w_prod    = r_neg ? (~r_acc + 64'd1) : r_acc;
    assign w_mul_exc = (w_prod[63:32] != {32{w_prod[31]}});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_op) begin
                    w_state_next = w_skip_busy ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_count == 6'd31) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= 6'd0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_shreg  <= 32'd0;
`ifdef MULTDIV_DIV_EN
            r_rem    <= 33'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_op) begin
                        r_count  <= 6'd0;
                        r_is_div <= w_is_div;
                        r_neg    <= dataA[31] ^ dataB[31];
                        r_err    <= w_skip_busy;
                        r_acc    <= 64'd0;
                        // Multiply: r_mcand = |A| shifted left, r_shreg = |B| shifted right.
                        // Divide:   r_mcand = |B| (static divisor), r_shreg = |A| becoming the quotient.
                        r_mcand  <= {32'd0, w_is_div ? w_abs_b : w_abs_a};
                        r_shreg  <= w_is_div ? w_abs_a : w_abs_b;
`ifdef MULTDIV_DIV_EN
                        r_rem    <= 33'd0;
`endif
                    end
                end
                S_BUSY: begin
                    r_count <= r_count + 6'd1;
                    if (!r_is_div) begin
                        if (r_shreg[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand <= {r_mcand[62:0], 1'b0};
                        r_shreg <= {1'b0, r_shreg[31:1]};
                    end
`ifdef MULTDIV_DIV_EN
                    else if (!w_rem_sub[32]) begin
                        r_rem   <= w_rem_sub;
                        r_shreg <= {r_shreg[30:0], 1'b1};
                    end else begin
                        r_rem   <= w_rem_shift;
                        r_shreg <= {r_shreg[30:0], 1'b0};
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result       = 32'd0;
        result_valid = 1'b0;
        exception    = 1'b0;
        stall        = 1'b0;
        if (!reset) begin
            stall = ((r_state == S_IDLE) && w_op) || (r_state == S_BUSY);
            if (r_state == S_DONE) begin
                result_valid = 1'b1;
                if (r_err) begin
                    exception = 1'b1;
                end
`ifdef MULTDIV_DIV_EN
                else if (r_is_div) begin
                    result    = w_quot;
                    exception = w_div_exc;
                end
`endif
                else begin
                    result    = w_prod[31:0];
                    exception = w_mul_exc;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_multdiv.sv
// Self-checking bench for execute_multdiv: directed and random mul/div ops against an arithmetic model.
// Expectations follow MULTDIV_DIV_EN when the bench is built with it.
module tb_execute_multdiv;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] instruction;
    logic [31:0] result;
    logic        result_valid;
    logic        exception;
    logic        stall;

    int n_pass  = 0;
    int n_total = 0;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    execute_multdiv dut (
        .clock        (clock),
        .reset        (reset),
        .dataA        (dataA),
        .dataB        (dataB),
        .instruction  (instruction),
        .result       (result),
        .result_valid (result_valid),
        .exception    (exception),
        .stall        (stall)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete (observed no finish, required finish)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] alu);
        logic [31:0] w;
        w        = $urandom;
        w[31:27] = 5'b00000;
        w[6:2]   = alu;
        return w;
    endfunction

    function automatic logic [31:0] mk_other();
        logic [31:0] w;
        w = $urandom;
        if (w[0]) begin
            w[31:27] = 5'b00000;
            w[6:2]   = 5'b00000;
        end else if (w[31:27] == 5'b00000) begin
            w[31:27] = 5'b00001;
        end
        return w;
    endfunction

    // Reference: plain signed arithmetic, latency counted from the start cycle.
    task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output int lat);
        longint p;
        int     sa;
        int     sb;
        logic [31:0] lo;
        sa = a;
        sb = b;
        if (!is_div) begin
            p   = longint'(sa) * longint'(sb);
            lo  = p[31:0];
            r   = lo;
            e   = (p != longint'($signed(lo)));
            lat = 33;
        end else if (!DIV_EN || b == 32'd0) begin
            r   = 32'd0;
            e   = 1'b1;
            lat = 1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r   = 32'h80000000;
            e   = 1'b1;
            lat = 33;
        end else begin
            r   = sa / sb;
            e   = 1'b0;
            lat = 33;
        end
    endtask

    // Called at the start cycle with the op on the inputs; ends at the result cycle.
    task automatic check_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        int          lat;
        model(is_div, a, b, r, e, lat);
        chk("start_stall", {31'd0, stall}, 32'd1);
        chk("start_valid", {31'd0, result_valid}, 32'd0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clock);
            if (c < lat) begin
                chk("busy_stall", {31'd0, stall}, 32'd1);
                chk("busy_valid", {31'd0, result_valid}, 32'd0);
                chk("busy_result", result, 32'd0);
                dataA = $urandom;
                dataB = $urandom;
            end else begin
                chk("done_valid", {31'd0, result_valid}, 32'd1);
                chk("done_result", result, r);
                chk("done_exc", {31'd0, exception}, {31'd0, e});
                chk("done_stall", {31'd0, stall}, 32'd0);
            end
        end
        $display("%s a=0x%08h b=0x%08h -> result=0x%08h exc=%0b latency=%0d",
                 is_div ? "div" : "mul", a, b, result, exception, lat);
    endtask

    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        instruction = mk_instr(is_div ? 5'b00111 : 5'b00110);
        dataA       = a;
        dataB       = b;
        #1;
        check_op(is_div, a, b);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            instruction = mk_other();
            dataA       = $urandom;
            dataB       = $urandom;
            #1;
            chk("idle_stall", {31'd0, stall}, 32'd0);
            chk("idle_valid", {31'd0, result_valid}, 32'd0);
        end
        $display("idle %0d cycles with non-mul/div instructions", n);
    endtask

    task automatic reset_mid_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        instruction = mk_instr(5'b00110);
        dataA       = a;
        dataB       = b;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            chk("rst_pre_stall", {31'd0, stall}, 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        @(negedge clock);
        chk("rst_hold_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_hold_result", result, 32'd0);
        reset = 1'b0;
        dataA = a;
        dataB = b;
        #1;
        $display("reset at T+10 of mul a=0x%08h b=0x%08h, restarting", a, b);
        check_op(1'b0, a, b);
    endtask

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(0, 1) == 0) return $urandom;
        return 32'($urandom_range(0, 400)) - 32'd200;
    endfunction

    initial begin
        reset       = 1'b1;
        instruction = mk_instr(5'b00110);
        dataA       = 32'd3;
        dataB       = 32'd4;
        repeat (3) @(negedge clock);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_exc", {31'd0, exception}, 32'd0);
        reset       = 1'b0;
        instruction = mk_other();
        idle_cycles(4);

        run_op(1'b0, 32'd7, 32'hFFFFFFFD);
        run_op(1'b0, 32'h00010000, 32'h00010000);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2);
        run_op(1'b1, 32'd5, 32'd0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_op(1'b1, 32'd9, 32'd3);
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF);
        idle_cycles(2);
        run_op(1'b0, 32'd3, 32'd4);
        run_op(1'b0, 32'd5, 32'd6);
        idle_cycles(2);
        reset_mid_op(32'h00001234, 32'hFFFF0010);
        idle_cycles(1);

        for (int i = 0; i < 20; i++) begin
            int          kind;
            logic [31:0] a;
            logic [31:0] b;
            kind = $urandom_range(0, 4);
            a    = rand_operand();
            b    = rand_operand();
            if (kind == 3 && $urandom_range(0, 3) == 0) b = 32'd0;
            if (kind == 4) idle_cycles($urandom_range(1, 3));
            else run_op(kind >= 2, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
